regfile_param: RTL and testbench



---
 rtl/regfile_param.sv | 121 ++++++++++++
 tb/tb_regfile_param.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with a one-entry-per-cycle clear sweep.
// Define REGFILE_BYPASS_EN to forward the WB write data to same-cycle reads.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] WD,
    input  logic              RegWriteW,
    input  logic              Clear,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2,
    output logic              Busy
);
    localparam int                IDX_W    = (NREG > 1) ? $clog2(NREG) : 1;
    localparam logic [ADDR_W:0]   NREG_EXT = (ADDR_W + 1)'(NREG);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

    typedef enum logic {SWEEP, IDLE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              busy_q, busy_d;
    logic              wr_legal;

    logic [DATA_W-1:0] mem [NREG];

    logic [1:0][ADDR_W-1:0] rd_addr;
    logic [1:0][DATA_W-1:0] rd_data;

    // An address is "live" when it names an implemented, writable register.
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < NREG_EXT) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign wr_legal = (state_q == IDLE) && RegWriteW && addr_live(A3);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= SWEEP;
            idx_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        case (state_q)
            SWEEP: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    busy_d  = 1'b0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            IDLE: begin
                if (Clear) begin
                    state_d = SWEEP;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = SWEEP;
                idx_d   = '0;
                busy_d  = 1'b1;
            end
        endcase
    end

    // Storage has no reset; a write coinciding with Clear lands and is then swept.
    always_ff @(posedge CLK) begin
        if (state_q == SWEEP) begin
            mem[idx_q[IDX_W-1:0]] <= '0;
        end else if (wr_legal) begin
            mem[A3[IDX_W-1:0]] <= WD;
        end
    end

    assign rd_addr = {A2, A1};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [DATA_W-1:0] data;
            always_comb begin
                data = '0;
                if ((state_q == IDLE) && addr_live(rd_addr[gi])) begin
`ifdef REGFILE_BYPASS_EN
                    if (wr_legal && (A3 == rd_addr[gi])) begin
                        data = WD;
                    end else begin
                        data = mem[rd_addr[gi][IDX_W-1:0]];
                    end
`else
                    data = mem[rd_addr[gi][IDX_W-1:0]];
`endif
                end
            end
            assign rd_data[gi] = data;
        end
    endgenerate

    assign RD1  = rd_data[0];
    assign RD2  = rd_data[1];
    assign Busy = busy_q;
endmodule

// File: tb/tb_regfile_param.sv
// Randomised bench for regfile_param: a 32-entry and a 20-entry instance share stimulus
// and are checked every cycle against an array-based model, plus directed literal checks.
module tb_regfile_param;
    logic        CLK = 1'b0;
    logic        RSTn;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD;
    logic        RegWriteW, Clear;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        busy_a, busy_b;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 CLK = ~CLK;

    regfile_param u_dut32 (
        .CLK(CLK), .RSTn(RSTn), .A1(A1), .A2(A2), .A3(A3), .WD(WD),
        .RegWriteW(RegWriteW), .Clear(Clear), .RD1(rd1_a), .RD2(rd2_a), .Busy(busy_a)
    );

    regfile_param #(.NREG(20)) u_dut20 (
        .CLK(CLK), .RSTn(RSTn), .A1(A1), .A2(A2), .A3(A3), .WD(WD),
        .RegWriteW(RegWriteW), .Clear(Clear), .RD1(rd1_b), .RD2(rd2_b), .Busy(busy_b)
    );

    // Model: sweep = "remaining busy posedges"; contents zeroed as soon as a sweep starts,
    // which is observably equivalent because reads are forced to 0 while busy.
    logic [31:0] mm [2][32];
    int          left [2];

    function automatic int nreg(input int u);
        return (u == 0) ? 32 : 20;
    endfunction

    always @(posedge CLK or negedge RSTn) begin
        for (int u = 0; u < 2; u++) begin
            if (!RSTn) begin
                left[u] <= nreg(u);
                for (int i = 0; i < 32; i++) mm[u][i] <= '0;
            end else if (left[u] > 0) begin
                left[u] <= left[u] - 1;
            end else begin
                if (RegWriteW && int'(A3) < nreg(u) && A3 != 5'd0) mm[u][A3] <= WD;
                if (Clear) begin
                    left[u] <= nreg(u);
                    for (int i = 0; i < 32; i++) mm[u][i] <= '0;
                end
            end
        end
    end

    function automatic logic [31:0] exp_rd(input int u, input logic [4:0] a);
        if (left[u] > 0 || int'(a) >= nreg(u) || a == 5'd0) return 32'd0;
`ifdef REGFILE_BYPASS_EN
        if (RegWriteW && A3 == a) return WD;
`endif
        return mm[u][a];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t act=%h exp=%h", name, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("rd1_32", rd1_a, exp_rd(0, A1));
            chk("rd2_32", rd2_a, exp_rd(0, A2));
            chk("busy_32", {31'd0, busy_a}, {31'd0, left[0] > 0});
            chk("rd1_20", rd1_b, exp_rd(1, A1));
            chk("rd2_20", rd2_b, exp_rd(1, A2));
            chk("busy_20", {31'd0, busy_b}, {31'd0, left[1] > 0});
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Counts posedges until each Busy falls; pulses Clear mid-sweep and drops any write.
    task automatic count_sweep(input string name);
        int n32 = -1;
        int n20 = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (n32 < 0 && !busy_a) n32 = k;
            if (n20 < 0 && !busy_b) n20 = k;
            if (k == 4) begin
                RegWriteW = 1'b0;
                Clear     = 1'b1;
            end else begin
                Clear = 1'b0;
            end
        end
        chk({name, "_len32"}, n32, 32);
        chk({name, "_len20"}, n20, 20);
        $display("sweep %s: len32=%0d len20=%0d", name, n32, n20);
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        RegWriteW = 1'b1;
        A3 = a;
        WD = d;
        step();
        RegWriteW = 1'b0;
    endtask

    initial begin
        RSTn = 1'b0;
        A1 = '0; A2 = '0; A3 = '0; WD = '0;
        RegWriteW = 1'b0; Clear = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        A1 = 5'd7;
        #1;
        chk("reset_busy", {31'd0, busy_a}, 32'd1);
        chk("reset_rd1", rd1_a, 32'd0);

        // Release reset with a write to r5 pending during the sweep; it must be lost.
        RSTn = 1'b1;
        RegWriteW = 1'b1; A3 = 5'd5; WD = 32'hDEADBEEF;
        count_sweep("reset");
        A1 = 5'd5;
        #1;
        chk("r5_lost", rd1_a, 32'd0);

        for (int a = 0; a < 32; a++) begin
            A1 = a[4:0];
            A2 = 5'(31 - a);
            step();
            $display("read a1=%0d rd1=%h rd2=%h", a, rd1_a, rd2_a);
        end

        wr(5'd7, 32'h12345678);
        A1 = 5'd7; A2 = 5'd7;
        #1;
        chk("r7_rd1", rd1_a, 32'h12345678);
        chk("r7_rd2", rd2_a, 32'h12345678);
        wr(5'd0, 32'hFFFFFFFF);
        A1 = 5'd0;
        #1;
        chk("r0_zero", rd1_a, 32'd0);

        RegWriteW = 1'b1; A3 = 5'd3; WD = 32'hA5A5A5A5; A1 = 5'd3;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("r3_same", rd1_a, 32'hA5A5A5A5);
`else
        chk("r3_same", rd1_a, 32'd0);
`endif
        step();
        RegWriteW = 1'b0;
        #1;
        chk("r3_next", rd1_a, 32'hA5A5A5A5);

        for (int i = 1; i < 32; i++) wr(i[4:0], 32'(i));
        A1 = 5'd17; A2 = 5'd19;
        #1;
        chk("fill_r17", rd1_a, 32'd17);
        chk("fill20_r19", rd2_b, 32'd19);

        Clear = 1'b1;
        RegWriteW = 1'b1; A3 = 5'd9; WD = 32'h99;
        step();
        Clear = 1'b0;
        chk("clear_busy", {31'd0, busy_a}, 32'd1);
        count_sweep("clear");
        A1 = 5'd9; A2 = 5'd31;
        #1;
        chk("r9_cleared", rd1_a, 32'd0);
        chk("r31_cleared", rd2_a, 32'd0);

        wr(5'd25, 32'hCAFEF00D);
        A1 = 5'd25; A2 = 5'd19;
        #1;
        chk("oor20_rd", rd1_b, 32'd0);
        chk("oor20_r19", rd2_b, 32'd0);
        chk("r25_32", rd1_a, 32'hCAFEF00D);

        Clear = 1'b1;
        step();
        Clear = 1'b0;
        for (int k = 0; k < 9; k++) step();
        RSTn = 1'b0;
        step();
        step();
        RSTn = 1'b1;
        count_sweep("midreset");

        for (int n = 0; n < 400; n++) begin
            RegWriteW = 1'($urandom_range(0, 1));
            A3 = 5'($urandom);
            WD = $urandom;
            A1 = ($urandom_range(0, 2) == 0) ? A3 : 5'($urandom);
            A2 = ($urandom_range(0, 2) == 0) ? A3 : 5'($urandom);
            Clear = ($urandom_range(0, 59) == 0);
            RSTn = ($urandom_range(0, 249) != 0);
            step();
            $display("rnd %0d we=%0d a3=%0d wd=%h a1=%0d rd1=%h a2=%0d rd2=%h busy=%0d",
                     n, RegWriteW, A3, WD, A1, rd1_a, A2, rd2_a, busy_a);
        end
        RSTn = 1'b1;
        RegWriteW = 1'b0;
        Clear = 1'b0;
        step();
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
